dual_update: RTL
================

// Module: dual_update
// PURPOSE
// ADMM dual-variable stage; runs directly after slack_update in each ADMM iteration.
// Updates input duals y += u - z and state duals g += x - v in place in the trajectory RAMs.
// Tracks infinity-norm residuals for the convergence check:
//   primal = max(|u-z|, |x-v|); dual = max |z - z_prev| (rho = 1).
// PARAMETERS
// STATE_DIM   12  state vector length (nx)
// INPUT_DIM   4   input vector length (nu)
// HORIZON     30  maximum MPC horizon (N)
// DATA_WIDTH  16  signed fixed-point word width
// FRAC_BITS   8   fractional bits (1.0 = 16'h0100)
// ADDR_WIDTH  9   RAM address width
// PORTS
// clk                  in   1           sole clock; all logic on posedge
// rst                  in   1           synchronous, active-high reset
// start                in   1           level; begin update when IDLE
// active_horizon       in   32          horizon in use this solve
// u_rdaddress/u_data_out            out/in  ADDR_WIDTH/DATA_WIDTH  input trajectory read
// z_rdaddress/z_data_out            out/in  ADDR_WIDTH/DATA_WIDTH  input slack read
// z_prev_rdaddress/z_prev_data_out  out/in  ADDR_WIDTH/DATA_WIDTH  previous slack read
// y_rdaddress/y_data_out            out/in  ADDR_WIDTH/DATA_WIDTH  input dual read
// y_wraddress, y_data_in, y_wren    out     ADDR_WIDTH/DATA_WIDTH/1  input dual write
// x_rdaddress/x_data_out            out/in  ADDR_WIDTH/DATA_WIDTH  state trajectory read
// v_rdaddress/v_data_out            out/in  ADDR_WIDTH/DATA_WIDTH  state slack read
// g_rdaddress/g_data_out            out/in  ADDR_WIDTH/DATA_WIDTH  state dual read
// g_wraddress, g_data_in, g_wren    out     ADDR_WIDTH/DATA_WIDTH/1  state dual write
// primal_residual      out  DATA_WIDTH  unsigned max |primal|, valid when done
// dual_residual        out  DATA_WIDTH  unsigned max |dual|, valid when done
// done                 out  1           high in DONE until start drops
// BEHAVIOUR
// - Reset: state=IDLE, all addresses, data_in, wren, residuals, done = 0. Reset mid-operation
//   aborts at that edge; no further writes; RAM contents left partially updated.
// - RAMs: registered read, data valid the cycle after the address is driven.
// - H = clamp(active_horizon, 0, HORIZON); Ny = INPUT_DIM*(H-1) (0 if H<=1); Ng = STATE_DIM*H.
// - FSM IDLE -> DUAL_Y -> DUAL_G -> DONE -> IDLE. start ignored outside IDLE.
// - IDLE + start: clear residuals and done; go to DUAL_Y (skip to DUAL_G if Ny=0).
//   H=0 goes straight to DONE with residuals 0.
// - Per element, flat index j, three cycles:
//   P0: drive all read addresses = j.
//   P1: wait.
//   P2: compute; drive wraddress=j, data_in, wren=1 for exactly this cycle.
// - DUAL_Y: j = 0..Ny-1. DUAL_G: j = 0..Ng-1. The last P2 moves to the next state.
// - Arithmetic: two's complement. d = sat(u - z); y_new = sat(y + d). Saturate to
//   [0x8000, 0x7FFF] at each step, never wrap. abs() of 0x8000 = 0x7FFF.
// - Residuals: running max of abs(d) into primal (both phases); abs(sat(z - z_prev))
//   into dual (DUAL_Y only).
// - Latency: done rises 3*(Ny+Ng)+1 cycles after the start edge is sampled.
// - DONE: done=1, wrens=0, residuals held; start low -> IDLE, done=0 next edge.
// - Element index k*dim+i matches slack_update memory layout; no address > Ng-1 is issued.
// STRUCTURE
// - mpc_pkg: typedef logic signed [DATA_WIDTH-1:0] fixed_t; FIX_MAX/FIX_MIN constants;
//   functions sat_add, sat_sub, abs_sat; FSM state enum shared with slack_update.
// - One sub-module: dual_elem_calc (combinational: cur, a, b -> new dual, |a-b|);
//   instantiate twice (y path, g path).
// TESTING
// 1 rst held 3 cycles then released -> all outputs 0, state IDLE, no wren pulses.
// 2 H=2, u=0x0200, z=0x0100, y=0, x=v, g=0x0040 -> y words become 0x0100, g unchanged,
//   primal=0x0100; done at cycle 3*(4+24)+1 = 85.
// 3 y=0x7F00, u=0x0200, z=0 -> y_data_in 0x7FFF (saturate); u=0x8000, z=0x7FFF -> |d|=0x7FFF.
// 4 z=0x0300, z_prev=0x0100 at one index, others equal -> dual_residual = 0x0200.
// 5 H=1 -> no y_wren pulses, 12 g writes; H=0 -> done 1 cycle later, residuals 0; H=40 -> clamped to 30.
// 6 rst asserted during DUAL_G -> wrens 0 next edge, done stays 0; new start runs normally.

Source files
------------

// File: rtl/mpc_pkg.sv
// Shared fixed-point types, saturating helpers and solver FSM states for the ADMM stages.
package mpc_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ADDR_WIDTH = 9;
  localparam int STATE_DIM  = 12;
  localparam int INPUT_DIM  = 4;
  localparam int HORIZON    = 30;

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;

  localparam fixed_t FIX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam fixed_t FIX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam fixed_t FIX_ONE = fixed_t'(1 << FRAC_BITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DUAL_Y,
    ST_DUAL_G,
    ST_DONE
  } mpc_state_e;

  // One guard bit is enough to detect overflow of a single add/sub.
  function automatic fixed_t sat_add(input fixed_t a, input fixed_t b);
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return s[DATA_WIDTH] ? FIX_MIN : FIX_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic fixed_t sat_sub(input fixed_t a, input fixed_t b);
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return s[DATA_WIDTH] ? FIX_MIN : FIX_MAX;
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic fixed_t abs_sat(input fixed_t a);
    if (a == FIX_MIN) return FIX_MAX;
    return a[DATA_WIDTH-1] ? -a : a;
  endfunction
endpackage

// File: rtl/dual_update_if.sv
// Control and trajectory-RAM bundle for dual_update; master = the update engine, slave = RAMs/sequencer.
interface dual_update_if;
  import mpc_pkg::*;

  logic                  start;
  logic [31:0]           active_horizon;
  logic                  done;
  logic [DATA_WIDTH-1:0] primal_residual;
  logic [DATA_WIDTH-1:0] dual_residual;

  logic [ADDR_WIDTH-1:0] u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress;
  logic [ADDR_WIDTH-1:0] x_rdaddress, v_rdaddress, g_rdaddress;
  fixed_t                u_data_out, z_data_out, z_prev_data_out, y_data_out;
  fixed_t                x_data_out, v_data_out, g_data_out;

  logic [ADDR_WIDTH-1:0] y_wraddress, g_wraddress;
  fixed_t                y_data_in, g_data_in;
  logic                  y_wren, g_wren;

  modport master (
    input  start, active_horizon,
    input  u_data_out, z_data_out, z_prev_data_out, y_data_out,
    input  x_data_out, v_data_out, g_data_out,
    output done, primal_residual, dual_residual,
    output u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress,
    output x_rdaddress, v_rdaddress, g_rdaddress,
    output y_wraddress, y_data_in, y_wren,
    output g_wraddress, g_data_in, g_wren
  );

  modport slave (
    output start, active_horizon,
    output u_data_out, z_data_out, z_prev_data_out, y_data_out,
    output x_data_out, v_data_out, g_data_out,
    input  done, primal_residual, dual_residual,
    input  u_rdaddress, z_rdaddress, z_prev_rdaddress, y_rdaddress,
    input  x_rdaddress, v_rdaddress, g_rdaddress,
    input  y_wraddress, y_data_in, y_wren,
    input  g_wraddress, g_data_in, g_wren
  );
endinterface

// File: rtl/dual_update_elem_calc.sv
// Single-element dual step: new = sat(cur + sat(a - b)), plus |a - b| for the residual.
module dual_elem_calc
  import mpc_pkg::*;
(
  input  fixed_t cur,
  input  fixed_t a,
  input  fixed_t b,
  output fixed_t new_dual,
  output fixed_t abs_diff
);
  fixed_t d;

  assign d        = sat_sub(a, b);
  assign new_dual = sat_add(cur, d);
  assign abs_diff = abs_sat(d);
endmodule

// File: rtl/dual_update.sv
// ADMM dual update: y += u - z, g += x - v in place, tracking inf-norm primal/dual residuals.
module dual_update
  import mpc_pkg::*;
(
  input logic         clk,
  input logic         rst,
  dual_update_if.master bus
);
  localparam int CW = 16;

  mpc_state_e state, state_nxt;

  logic [CW-1:0]         h_clamp, ny_start, ng_start;
  logic [CW-1:0]         ny, ng, j;
  logic [1:0]            phase;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  run, in_y, calc_en, elem_end, j_last;

  fixed_t                y_new, y_absd, g_new, g_absd, z_absd;
  logic [DATA_WIDTH-1:0] y_absd_u, g_absd_u, z_absd_u;

  // Horizon is clamped once at start and the element counts latched for the whole run.
  always_comb begin
    h_clamp = '0;
    if ($signed(bus.active_horizon) <= 0)
      h_clamp = '0;
    else if ($signed(bus.active_horizon) > HORIZON)
      h_clamp = CW'(HORIZON);
    else
      h_clamp = bus.active_horizon[CW-1:0];
  end

  assign ny_start = (h_clamp <= 1) ? '0 : CW'(INPUT_DIM) * (h_clamp - 1'b1);
  assign ng_start = CW'(STATE_DIM) * h_clamp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (bus.start) begin
          if (h_clamp == 0)       state_nxt = ST_DONE;
          else if (ny_start == 0) state_nxt = ST_DUAL_G;
          else                    state_nxt = ST_DUAL_Y;
        end
      ST_DUAL_Y: if (elem_end && j_last) state_nxt = ST_DUAL_G;
      ST_DUAL_G: if (elem_end && j_last) state_nxt = ST_DONE;
      ST_DONE:   if (bus.done && !bus.start) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    run      = (state == ST_DUAL_Y) || (state == ST_DUAL_G);
    in_y     = (state == ST_DUAL_Y);
    calc_en  = run && (phase == 2'd1);
    elem_end = run && (phase == 2'd2);
    j_last   = in_y ? (j == ny - 1'b1) : (j == ng - 1'b1);
  end

  dual_elem_calc u_y_calc (
    .cur(bus.y_data_out), .a(bus.u_data_out), .b(bus.z_data_out),
    .new_dual(y_new), .abs_diff(y_absd)
  );

  dual_elem_calc u_g_calc (
    .cur(bus.g_data_out), .a(bus.x_data_out), .b(bus.v_data_out),
    .new_dual(g_new), .abs_diff(g_absd)
  );

  assign z_absd   = abs_sat(sat_sub(bus.z_data_out, bus.z_prev_data_out));
  assign y_absd_u = y_absd;
  assign g_absd_u = g_absd;
  assign z_absd_u = z_absd;

  // Datapath: read data arrives during P1, so results are registered at the P1->P2 edge
  // and the write strobe is visible for exactly the P2 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ny                  <= '0;
      ng                  <= '0;
      j                   <= '0;
      phase               <= '0;
      rd_addr             <= '0;
      bus.y_wraddress     <= '0;
      bus.y_data_in       <= '0;
      bus.y_wren          <= 1'b0;
      bus.g_wraddress     <= '0;
      bus.g_data_in       <= '0;
      bus.g_wren          <= 1'b0;
      bus.primal_residual <= '0;
      bus.dual_residual   <= '0;
      bus.done            <= 1'b0;
    end else begin
      bus.y_wren <= 1'b0;
      bus.g_wren <= 1'b0;
      // done drops on the same edge the FSM leaves DONE
      bus.done   <= (state == ST_DONE) && !(bus.done && !bus.start);

      if (state == ST_IDLE && bus.start) begin
        bus.primal_residual <= '0;
        bus.dual_residual   <= '0;
        ny                  <= ny_start;
        ng                  <= ng_start;
        j                   <= '0;
        phase               <= '0;
        rd_addr             <= '0;
      end

      if (run) phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;

      if (calc_en) begin
        if (in_y) begin
          bus.y_wraddress <= rd_addr;
          bus.y_data_in   <= y_new;
          bus.y_wren      <= 1'b1;
          if (y_absd_u > bus.primal_residual) bus.primal_residual <= y_absd_u;
          if (z_absd_u > bus.dual_residual)   bus.dual_residual   <= z_absd_u;
        end else begin
          bus.g_wraddress <= rd_addr;
          bus.g_data_in   <= g_new;
          bus.g_wren      <= 1'b1;
          if (g_absd_u > bus.primal_residual) bus.primal_residual <= g_absd_u;
        end
      end

      if (elem_end) begin
        if (j_last) begin
          j       <= '0;
          rd_addr <= '0;
        end else begin
          j       <= j + 1'b1;
          rd_addr <= ADDR_WIDTH'(j + 1'b1);
        end
      end
    end
  end

  assign bus.u_rdaddress      = rd_addr;
  assign bus.z_rdaddress      = rd_addr;
  assign bus.z_prev_rdaddress = rd_addr;
  assign bus.y_rdaddress      = rd_addr;
  assign bus.x_rdaddress      = rd_addr;
  assign bus.v_rdaddress      = rd_addr;
  assign bus.g_rdaddress      = rd_addr;
endmodule
